// File: rtl/stream_checksum_gen_pkg.sv
// Shared framing types and ones'-complement helpers for the checksum generator and its parser.
package stream_checksum_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        TRAILER
    } gen_state_t;

    typedef struct packed {
        gen_state_t  state;
        logic [15:0] count;
        logic [15:0] sum;
    } gen_self_t;

    // 16-bit ones'-complement add: the carry out wraps back into bit 0.
    // The wrapped result cannot carry a second time.
    function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    function automatic logic [15:0] fold_32(input logic [15:0] sum, input logic [31:0] word);
        return ones_add16(ones_add16(sum, word[31:16]), word[15:0]);
    endfunction

endpackage

// File: rtl/stream_checksum_gen.sv
// Transmit framer: forwards payload through one register stage and appends a
// {word_count, ~checksum} trailer after each packet.
module stream_checksum_gen
    import stream_checksum_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] stream_in_data,
    input  logic                  stream_in_valid,
    input  logic                  stream_in_last,
    output logic                  stream_in_ready,
    output logic [DATA_WIDTH-1:0] stream_out_data,
    output logic                  stream_out_valid,
    output logic                  stream_out_last,
    input  logic                  stream_out_ready
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("stream_checksum_gen supports DATA_WIDTH == 32 only");
    end
    if (COUNT_WIDTH < 1) begin : g_bad_count
        $error("stream_checksum_gen needs COUNT_WIDTH >= 1");
    end

    // Only the low 16 bits of the counter are ever visible, so a 16-bit
    // register masked to COUNT_WIDTH gives identical results for any width.
    localparam logic [15:0] CNT_MASK = (COUNT_WIDTH >= 16) ? 16'hFFFF
                                     : 16'((32'd1 << COUNT_WIDTH) - 32'd1);

    gen_self_t             self_q, self_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  reg_free, in_xfer, out_xfer;

    assign reg_free        = !valid_q || stream_out_ready;
    assign stream_in_ready = (self_q.state != TRAILER) && reg_free;
    assign in_xfer         = stream_in_valid && stream_in_ready;
    assign out_xfer        = valid_q && stream_out_ready;

    always_comb begin
        self_d  = self_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (in_xfer) begin
            // count and sum are zero in IDLE, so opening a packet is the same update
            data_d       = stream_in_data;
            valid_d      = 1'b1;
            last_d       = 1'b0;
            self_d.count = (self_q.count + 16'd1) & CNT_MASK;
            self_d.sum   = fold_32(self_q.sum, stream_in_data);
            self_d.state = stream_in_last ? TRAILER : PAYLOAD;
        end else if (self_q.state == TRAILER && reg_free) begin
            data_d       = {self_q.count, ~self_q.sum};
            valid_d      = 1'b1;
            last_d       = 1'b1;
            self_d.count = '0;
            self_d.sum   = '0;
            self_d.state = IDLE;
        end else if (out_xfer) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            self_q  <= '{state: IDLE, count: '0, sum: '0};
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            self_q  <= self_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign stream_out_data  = data_q;
    assign stream_out_valid = valid_q;
    assign stream_out_last  = last_q;

endmodule

// File: tb/tb_stream_checksum_gen.sv
// Scoreboard bench for stream_checksum_gen: an independent modular-sum model
// predicts every payload and trailer word.
module tb_stream_checksum_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] stream_in_data;
    logic        stream_in_valid;
    logic        stream_in_last;
    logic        stream_in_ready;
    logic [31:0] stream_out_data;
    logic        stream_out_valid;
    logic        stream_out_last;
    logic        stream_out_ready;

    int          n_chk = 0;
    int          n_err = 0;
    int          rdy_mode = 0;   // 0 always ready, 1 random, 3 driven by the main sequence
    logic [32:0] exp_q[$];
    longint      m_tot = 0;
    int          m_cnt = 0;

    stream_checksum_gen #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .stream_in_data   (stream_in_data),
        .stream_in_valid  (stream_in_valid),
        .stream_in_last   (stream_in_last),
        .stream_in_ready  (stream_in_ready),
        .stream_out_data  (stream_out_data),
        .stream_out_valid (stream_out_valid),
        .stream_out_last  (stream_out_last),
        .stream_out_ready (stream_out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       stream_out_ready = 1'b1;
            1:       stream_out_ready = ($urandom_range(0, 3) != 0);
            default: ;
        endcase
    end

    // Scoreboard consumer plus hold-stable check across stalls.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {31'd0, stream_out_valid}, 32'd1);
                chk("hold_data", stream_out_data, prev_data);
                chk("hold_last", {31'd0, stream_out_last}, {31'd0, prev_last});
            end
            if (stream_out_valid && stream_out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("sb_data", stream_out_data, e[31:0]);
                    chk("sb_last", {31'd0, stream_out_last}, {31'd0, e[32]});
                end
            end
            prev_stall = stream_out_valid && !stream_out_ready;
            prev_data  = stream_out_data;
            prev_last  = stream_out_last;
        end
    end

    // Model: end-around-carry sum of halves equals the plain total reduced
    // mod 0xFFFF, with zero only when every half was zero.
    function automatic logic [31:0] model_trailer();
        longint s;
        s = (m_tot == 0) ? 0 : ((m_tot - 1) % 65535) + 1;
        return {m_cnt[15:0], ~s[15:0]};
    endfunction

    task automatic send_word(input logic [31:0] d, input logic l, output int waits);
        bit acc = 0;
        waits = 0;
        stream_in_valid = 1'b1;
        stream_in_data  = d;
        stream_in_last  = l;
        for (int n = 0; n < 500 && !acc; n++) begin
            @(negedge clk);
            if (stream_in_ready) begin
                acc = 1;
                exp_q.push_back({1'b0, d});
                m_tot += longint'(d[31:16]) + longint'(d[15:0]);
                m_cnt++;
                if (l) begin
                    exp_q.push_back({1'b1, model_trailer()});
                    m_tot = 0;
                    m_cnt = 0;
                end
            end
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        if (!acc) chk("in_accept_timeout", 32'd0, 32'd1);
        stream_in_valid = 1'b0;
        stream_in_data  = $urandom;
        stream_in_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_trailer(input string tag, input logic [31:0] exp);
        bit found = 0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            if (stream_out_valid && stream_out_ready && stream_out_last) begin
                found = 1;
                chk(tag, stream_out_data, exp);
            end
        end
        if (!found) chk({tag, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int w;
        reset           = 1'b1;
        stream_in_valid = 1'b0;
        stream_in_data  = '0;
        stream_in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, stream_out_valid}, 32'd0);
        chk("rst_last", {31'd0, stream_out_last}, 32'd0);
        chk("rst_data", stream_out_data, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, stream_in_ready}, 32'd1);

        // single-word packet and one-cycle latency
        send_word(32'h0001_0002, 1'b1, w);
        chk("t1_lat_valid", {31'd0, stream_out_valid}, 32'd1);
        chk("t1_lat_data", stream_out_data, 32'h0001_0002);
        wait_trailer("t1_trailer", 32'h0001_FFFC);

        // carry fold
        send_word(32'hFFFF_0001, 1'b0, w);
        send_word(32'h0000_0000, 1'b1, w);
        wait_trailer("t2_trailer", 32'h0002_FFFE);

        // zero payload, then back-to-back packet takes exactly one input bubble
        send_word(32'h0, 1'b0, w);
        send_word(32'h0, 1'b0, w);
        send_word(32'h0, 1'b1, w);
        send_word(32'h1234_5678, 1'b1, w);
        chk("t3_bubble", w, 32'd1);
        drain();

        // backpressure mid-packet
        rdy_mode = 3;
        stream_out_ready = 1'b1;
        send_word(32'hA5A5_0001, 1'b0, w);
        send_word(32'h5A5A_0002, 1'b0, w);
        stream_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_in_ready", {31'd0, stream_in_ready}, 32'd0);
            chk("t4_out_data", stream_out_data, 32'h5A5A_0002);
            @(posedge clk);
            #1;
        end
        stream_out_ready = 1'b1;
        send_word(32'hDEAD_BEEF, 1'b0, w);
        send_word(32'h0BAD_F00D, 1'b1, w);
        drain();
        rdy_mode = 0;

        // randomized packets, gaps and downstream stalls
        rdy_mode = 1;
        for (int p = 0; p < 6; p++) begin
            int len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                send_word($urandom, 1'(i == len - 1), w);
            end
        end
        rdy_mode = 0;
        drain();

        // count wraps past 2^16
        for (int i = 0; i < 65537; i++) send_word(32'h0000_0001, 1'(i == 65536), w);
        wait_trailer("t5_trailer", 32'h0001_FFFD);

        // reset mid-packet discards partial state
        send_word(32'h1111_2222, 1'b0, w);
        send_word(32'h3333_4444, 1'b0, w);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_valid_clr", {31'd0, stream_out_valid}, 32'd0);
        exp_q.delete();
        m_tot = 0;
        m_cnt = 0;
        reset = 1'b0;
        chk("t6_in_ready", {31'd0, stream_in_ready}, 32'd1);
        send_word(32'h0001_0002, 1'b1, w);
        wait_trailer("t6_trailer", 32'h0001_FFFC);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
